memory_dreq_issue: RTL and testbench



---
 rtl/memory_dreq_issue.sv | 195 +++++++++++++++++++
 tb/tb_memory_dreq_issue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_dreq_issue.sv
// Memory-stage data-bus request issuer: formats one dreq, runs the addr_ok/data_ok
// handshake and stalls the pipeline. Optional misalignment trap: MEM_ALIGN_CHECK_EN.
module memory_dreq_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_write,
    input  logic [31:0] in_addr,
    input  logic [1:0]  in_msize,
    input  logic [1:0]  in_lr,
    input  logic [31:0] in_wdata,
    input  logic        flush,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] raw_data,
    output logic        misalign
);

    localparam logic [1:0] MSIZE1   = 2'd0;
    localparam logic [1:0] MSIZE2   = 2'd1;
    localparam logic [1:0] MSIZE4   = 2'd2;
    localparam logic [1:0] LR_NORM  = 2'b00;
    localparam logic [1:0] LR_LEFT  = 2'b01;
    localparam logic [1:0] LR_RIGHT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t      state;
    logic        is_load;
    logic [1:0]  off;
    logic [1:0]  left_off;
    logic [4:0]  lane_sh;
    logic [4:0]  left_sh;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [3:0]  req_strobe;
    logic [31:0] req_data;
    logic        misaligned;

    assign off      = in_addr[1:0];
    assign left_off = 2'(2'd3 - off);
    assign lane_sh  = {off, 3'b000};
    assign left_sh  = {left_off, 3'b000};

    // Lane-align store data and build byte strobes from the unaligned-access variant.
    always_comb begin
        req_addr   = in_addr;
        req_size   = in_msize;
        req_strobe = 4'b0000;
        req_data   = 32'h0;
        case (in_lr)
            LR_LEFT: begin
                req_addr   = {in_addr[31:2], 2'b00};
                req_size   = MSIZE4;
                req_data   = in_wdata >> left_sh;
                req_strobe = 4'b1111 >> left_off;
            end
            LR_RIGHT: begin
                req_addr   = {in_addr[31:2], 2'b00};
                req_size   = MSIZE4;
                req_data   = in_wdata << lane_sh;
                req_strobe = 4'b1111 << off;
            end
            default: begin
                case (in_msize)
                    MSIZE1: begin
                        req_data   = {4{in_wdata[7:0]}};
                        req_strobe = 4'b0001 << off;
                    end
                    MSIZE2: begin
                        req_data   = {2{in_wdata[15:0]}};
                        req_strobe = 4'b0011 << off;
                    end
                    default: begin
                        req_data   = in_wdata;
                        req_strobe = 4'b1111;
                    end
                endcase
            end
        endcase
        if (!in_write) begin
            req_strobe = 4'b0000;
            req_data   = 32'h0;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (in_lr == LR_NORM) &&
                        (((in_msize == MSIZE2) && in_addr[0]) ||
                         ((in_msize == MSIZE4) && (in_addr[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    // Pipeline hold: must react in the same cycle the instruction appears.
    always_comb begin
        stall = 1'b0;
        case (state)
            S_IDLE:         stall = in_valid && !flush;
            S_REQ, S_WAIT:  stall = !flush;
            S_DRAIN:        stall = 1'b1;
            default:        stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            is_load     <= 1'b0;
            dreq_valid  <= 1'b0;
            dreq_addr   <= 32'h0;
            dreq_size   <= 2'd0;
            dreq_strobe <= 4'b0000;
            dreq_data   <= 32'h0;
            done        <= 1'b0;
            raw_data    <= 32'h0;
            misalign    <= 1'b0;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        if (misaligned) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                        end else begin
                            state       <= S_REQ;
                            is_load     <= !in_write;
                            dreq_valid  <= 1'b1;
                            dreq_addr   <= req_addr;
                            dreq_size   <= req_size;
                            dreq_strobe <= req_strobe;
                            dreq_data   <= req_data;
                        end
                    end
                end
                S_REQ: begin
                    if (dresp_addr_ok) begin
                        dreq_valid <= 1'b0;
                        if (dresp_data_ok) begin
                            if (is_load) raw_data <= dresp_data;
                            // A flushed instruction that completes anyway reports nothing.
                            if (flush) begin
                                state <= S_IDLE;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            state <= flush ? S_DRAIN : S_WAIT;
                        end
                    end else if (flush) begin
                        dreq_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (dresp_data_ok) begin
                        if (is_load) raw_data <= dresp_data;
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE: state <= S_IDLE;
                S_DRAIN: begin
                    if (dresp_data_ok) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_dreq_issue.sv
// Scoreboard bench for memory_dreq_issue: directed accesses push expected requests and
// completions; a negedge monitor compares them when the DUT presents them.
module tb_memory_dreq_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_write;
    logic [31:0] in_addr;
    logic [1:0]  in_msize;
    logic [1:0]  in_lr;
    logic [31:0] in_wdata;
    logic        flush;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;
    logic        stall;
    logic        done;
    logic [31:0] raw_data;
    logic        misalign;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic        chk_data;
    } req_exp_t;

    typedef struct {
        logic [31:0] raw;
        logic        mis;
    } done_exp_t;

    req_exp_t  req_q[$];
    done_exp_t done_q[$];
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_raw;

    memory_dreq_issue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_write(in_write),
        .in_addr(in_addr), .in_msize(in_msize), .in_lr(in_lr), .in_wdata(in_wdata),
        .flush(flush), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .stall(stall), .done(done), .raw_data(raw_data),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input logic [31:0] a, input logic [1:0] sz,
                              input logic [3:0] stb, input logic [31:0] d, input logic cd);
        req_exp_t e;
        e.addr = a; e.size = sz; e.strobe = stb; e.data = d; e.chk_data = cd;
        req_q.push_back(e);
    endtask

    task automatic expect_done(input logic [31:0] raw, input logic mis);
        done_exp_t e;
        e.raw = raw; e.mis = mis;
        done_q.push_back(e);
    endtask

    // Present one instruction for a single cycle; the DUT is in REQ (or DONE) afterwards.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                         input logic [1:0] lr, input logic [31:0] wd);
        in_valid = 1'b1; in_write = wr; in_addr = a; in_msize = sz; in_lr = lr; in_wdata = wd;
        @(negedge clk);
        chk("stall_on_issue", 32'(stall), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Drive the handshake from REQ through DONE back to IDLE.
    task automatic complete(input int addr_wait, input int data_wait, input logic [31:0] rd);
        repeat (addr_wait) begin
            @(negedge clk);
            chk("stall_req", 32'(stall), 32'd1);
            chk("valid_held", 32'(dreq_valid), 32'd1);
            tick();
        end
        dresp_addr_ok = 1'b1;
        if (data_wait == 0) begin
            dresp_data_ok = 1'b1;
            dresp_data = rd;
        end
        tick();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        if (data_wait > 0) begin
            repeat (data_wait - 1) begin
                @(negedge clk);
                chk("stall_wait", 32'(stall), 32'd1);
                chk("valid_dropped", 32'(dreq_valid), 32'd0);
                tick();
            end
            dresp_data_ok = 1'b1;
            dresp_data = rd;
            tick();
            dresp_data_ok = 1'b0;
        end
        @(negedge clk);
        chk("stall_done", 32'(stall), 32'd0);
        tick();
    endtask

    // Monitor: accepted requests and completion pulses are matched against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (dreq_valid && dresp_addr_ok) begin
                if (req_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_req: got addr %h expected no request", dreq_addr);
                end else begin
                    req_exp_t e;
                    e = req_q.pop_front();
                    chk("req_addr", dreq_addr, e.addr);
                    chk("req_size", 32'(dreq_size), 32'(e.size));
                    chk("req_strobe", 32'(dreq_strobe), 32'(e.strobe));
                    if (e.chk_data) chk("req_data", dreq_data, e.data);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 at %0t", $time);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    chk("done_raw_data", raw_data, d.raw);
                    chk("done_misalign", 32'(misalign), 32'(d.mis));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_write = 1'b0; in_addr = 32'h0; in_msize = 2'd0;
        in_lr = 2'b00; in_wdata = 32'h0; flush = 1'b0; dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0; dresp_data = 32'h0; exp_raw = 32'h0;
        tick(); tick();
        @(negedge clk);
        chk("rst_dreq_valid", 32'(dreq_valid), 32'd0);
        chk("rst_dreq_addr", dreq_addr, 32'h0);
        chk("rst_dreq_size", 32'(dreq_size), 32'd0);
        chk("rst_dreq_strobe", 32'(dreq_strobe), 32'd0);
        chk("rst_dreq_data", dreq_data, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_raw_data", raw_data, 32'h0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Load word, minimum latency
        expect_req(32'h1000, 2'd2, 4'b0000, 32'h0, 1'b0);
        expect_done(32'hDEADBEEF, 1'b0);
        exp_raw = 32'hDEADBEEF;
        issue(1'b0, 32'h1000, 2'd2, 2'b00, 32'h0);
        complete(0, 0, 32'hDEADBEEF);

        // Byte store, top lane, with addr and data waits; raw_data untouched
        expect_req(32'h2003, 2'd0, 4'b1000, 32'hA5A5A5A5, 1'b1);
        expect_done(exp_raw, 1'b0);
        issue(1'b1, 32'h2003, 2'd0, 2'b00, 32'h123456A5);
        complete(2, 2, 32'h77777777);

        // Half store upper lanes
        expect_req(32'h2002, 2'd1, 4'b1100, 32'hBEEFBEEF, 1'b1);
        expect_done(exp_raw, 1'b0);
        issue(1'b1, 32'h2002, 2'd1, 2'b00, 32'h1234BEEF);
        complete(1, 0, 32'h0);

        // Word store
        expect_req(32'h2000, 2'd2, 4'b1111, 32'hCAFEF00D, 1'b1);
        expect_done(exp_raw, 1'b0);
        issue(1'b1, 32'h2000, 2'd2, 2'b00, 32'hCAFEF00D);
        complete(0, 1, 32'h0);

        // SWL / SWR, including offset boundaries
        expect_req(32'h3000, 2'd2, 4'b0011, 32'h00001122, 1'b1);
        expect_done(exp_raw, 1'b0);
        issue(1'b1, 32'h3001, 2'd0, 2'b01, 32'h11223344);
        complete(0, 0, 32'h0);
        expect_req(32'h3000, 2'd2, 4'b1100, 32'h33440000, 1'b1);
        expect_done(exp_raw, 1'b0);
        issue(1'b1, 32'h3002, 2'd0, 2'b10, 32'h11223344);
        complete(0, 0, 32'h0);
        expect_req(32'h3000, 2'd2, 4'b0001, 32'h00000011, 1'b1);
        expect_done(exp_raw, 1'b0);
        issue(1'b1, 32'h3000, 2'd2, 2'b01, 32'h11223344);
        complete(0, 0, 32'h0);
        expect_req(32'h3000, 2'd2, 4'b1000, 32'h44000000, 1'b1);
        expect_done(exp_raw, 1'b0);
        issue(1'b1, 32'h3003, 2'd2, 2'b10, 32'h11223344);
        complete(0, 0, 32'h0);

        // LWL: word-aligned address, size forced to word, no strobes
        expect_req(32'h5000, 2'd2, 4'b0000, 32'h0, 1'b0);
        expect_done(32'h0BADF00D, 1'b0);
        exp_raw = 32'h0BADF00D;
        issue(1'b0, 32'h5003, 2'd0, 2'b01, 32'hFFFFFFFF);
        complete(0, 3, 32'h0BADF00D);

        // Aligned half load
        expect_req(32'h6002, 2'd1, 4'b0000, 32'h0, 1'b0);
        expect_done(32'h13579BDF, 1'b0);
        exp_raw = 32'h13579BDF;
        issue(1'b0, 32'h6002, 2'd1, 2'b00, 32'h0);
        complete(1, 1, 32'h13579BDF);

        // addr_ok withheld 5 cycles: request held stable, then withdrawn by flush
        issue(1'b1, 32'h7001, 2'd0, 2'b00, 32'h0000005A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(dreq_valid), 32'd1);
            chk("hold_addr", dreq_addr, 32'h7001);
            chk("hold_strobe", 32'(dreq_strobe), 32'b0010);
            chk("hold_data", dreq_data, 32'h5A5A5A5A);
            tick();
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_req_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_req_valid", 32'(dreq_valid), 32'd0);
        chk("flush_req_stall_after", 32'(stall), 32'd0);
        tick(); tick();

        // Flush beats a new issue in IDLE
        in_valid = 1'b1; in_write = 1'b0; in_addr = 32'h7100; in_msize = 2'd2; in_lr = 2'b00;
        flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_stall", 32'(stall), 32'd0);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_no_req", 32'(dreq_valid), 32'd0);
        tick();

        // Flush in WAIT: drain discards the response
        expect_req(32'h8000, 2'd2, 4'b0000, 32'h0, 1'b0);
        issue(1'b0, 32'h8000, 2'd2, 2'b00, 32'h0);
        dresp_addr_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        flush = 1'b1;
        tick();
        @(negedge clk);
        chk("drain_stall_a", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("drain_stall_b", 32'(stall), 32'd1);
        flush = 1'b0;
        dresp_data_ok = 1'b1;
        dresp_data = 32'h12345678;
        tick();
        dresp_data_ok = 1'b0;
        @(negedge clk);
        chk("drain_raw_kept", raw_data, exp_raw);
        chk("drain_idle_stall", 32'(stall), 32'd0);
        chk("drain_no_done", 32'(done), 32'd0);
        tick();

        // Misaligned half load
`ifdef MEM_ALIGN_CHECK_EN
        expect_done(exp_raw, 1'b1);
        issue(1'b0, 32'h4001, 2'd1, 2'b00, 32'h0);
        @(negedge clk);
        chk("misalign_no_req", 32'(dreq_valid), 32'd0);
        tick();
`else
        expect_req(32'h4001, 2'd1, 4'b0000, 32'h0, 1'b0);
        expect_done(32'h55AA55AA, 1'b0);
        exp_raw = 32'h55AA55AA;
        issue(1'b0, 32'h4001, 2'd1, 2'b00, 32'h0);
        complete(0, 0, 32'h55AA55AA);
`endif

        // Reset mid-transaction abandons it
        expect_req(32'h9000, 2'd2, 4'b0000, 32'h0, 1'b0);
        issue(1'b0, 32'h9000, 2'd2, 2'b00, 32'h0);
        dresp_addr_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(dreq_valid), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_raw", raw_data, 32'h0);
        tick(); tick();

        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        chk("done_queue_drained", 32'(done_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
